// File: rtl/dec_ascii_uart_tx.sv
// Snapshots the 14 ASCII digits from the binary-to-decimal converter, optionally drops
// leading '0' characters, appends CR LF and sends the string as 8N1 UART frames.
module dec_ascii_uart_tx #(
  parameter int unsigned CLKS_PER_BIT          = 868,
  parameter bit          LEADING_ZERO_SUPPRESS = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [5:0] char14,
  input  logic [5:0] char13,
  input  logic [5:0] char12,
  input  logic [5:0] char11,
  input  logic [5:0] char10,
  input  logic [5:0] char9,
  input  logic [5:0] char8,
  input  logic [5:0] char7,
  input  logic [5:0] char6,
  input  logic [5:0] char5,
  input  logic [5:0] char4,
  input  logic [5:0] char3,
  input  logic [5:0] char2,
  input  logic [5:0] char1,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int unsigned             BAUD_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0]       BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam int unsigned             NUM_DIGITS = 14;
  localparam logic [3:0]              IDX_CR     = 4'd14;
  localparam logic [3:0]              IDX_LF     = 4'd15;
  localparam logic [5:0]              ASCII_ZERO = 6'd48;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_START,
    S_DATA,
    S_STOP,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [5:0]          r_chars [NUM_DIGITS];
  logic [3:0]          r_idx;
  logic [2:0]          r_bit;
  logic [BAUD_W-1:0]   r_baud;

  logic [3:0]          w_first;
  logic [7:0]          w_byte;
  logic                w_baud_end;

  // Slot 0 holds char14 (MSD); the lowest-numbered non-'0' slot is sent first, char1 always survives.
  always_comb begin
    w_first = LEADING_ZERO_SUPPRESS ? 4'(NUM_DIGITS - 1) : 4'd0;
    if (LEADING_ZERO_SUPPRESS) begin
      for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
        if (r_chars[i] != ASCII_ZERO) begin
          w_first = 4'(i);
        end
      end
    end
  end

  always_comb begin
    w_byte = 8'h00;
    case (r_idx)
      IDX_CR:  w_byte = 8'h0D;
      IDX_LF:  w_byte = 8'h0A;
      default: w_byte = {2'b00, r_chars[r_idx]};
    endcase
  end

  assign w_baud_end = (r_baud == BAUD_LAST);

  // tx is produced from the current state, so the line lags the state by one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_idx   <= 4'd0;
      r_bit   <= 3'd0;
      r_baud  <= '0;
      tx      <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        r_chars[i] <= 6'd0;
      end
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          tx <= 1'b1;
          if (start) begin
            r_chars[0]  <= char14;
            r_chars[1]  <= char13;
            r_chars[2]  <= char12;
            r_chars[3]  <= char11;
            r_chars[4]  <= char10;
            r_chars[5]  <= char9;
            r_chars[6]  <= char8;
            r_chars[7]  <= char7;
            r_chars[8]  <= char6;
            r_chars[9]  <= char5;
            r_chars[10] <= char4;
            r_chars[11] <= char3;
            r_chars[12] <= char2;
            r_chars[13] <= char1;
            busy        <= 1'b1;
            r_state     <= S_SCAN;
          end
        end

        S_SCAN: begin
          tx      <= 1'b1;
          r_idx   <= w_first;
          r_bit   <= 3'd0;
          r_baud  <= '0;
          r_state <= S_START;
        end

        S_START: begin
          tx <= 1'b0;
          if (w_baud_end) begin
            r_baud  <= '0;
            r_bit   <= 3'd0;
            r_state <= S_DATA;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end

        S_DATA: begin
          tx <= w_byte[r_bit];
          if (w_baud_end) begin
            r_baud <= '0;
            if (r_bit == 3'd7) begin
              r_state <= S_STOP;
            end else begin
              r_bit <= r_bit + 1'b1;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end

        S_STOP: begin
          tx <= 1'b1;
          if (w_baud_end) begin
            r_baud <= '0;
            if (r_idx == IDX_LF) begin
              r_state <= S_DONE;
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_state <= S_START;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end

        S_DONE: begin
          tx      <= 1'b1;
          done    <= 1'b1;
          busy    <= 1'b0;
          r_idx   <= 4'd0;
          r_state <= S_IDLE;
        end

        default: begin
          tx      <= 1'b1;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dec_ascii_uart_tx.sv
// Scoreboard bench: two instances (suppression on / off) share stimulus; expected strings
// come from a string-level model, a UART monitor decodes tx and checks frames, timing and done.
module tb_dec_ascii_uart_tx;

  localparam int unsigned CPB   = 4;
  localparam int unsigned FRAME = 10 * CPB;

  typedef struct {
    int n;
    int s;
  } msg_t;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [5:0] ch [14];
  logic [1:0] tx_w, busy_w, done_w;

  logic [7:0] bq0[$], bq1[$];
  msg_t       mq0[$], mq1[$];
  int         free_at [2];
  int         cyc  = 0;
  int         nvec = 0;
  int         nerr = 0;

  bit             act [2];
  bit             in_msg [2];
  bit             fin [2];
  int             cnt [2];
  int             rem [2];
  int             t0 [2];
  int             nb [2];
  logic [FRAME-1:0] sh [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dec_ascii_uart_tx #(.CLKS_PER_BIT(CPB), .LEADING_ZERO_SUPPRESS(1'b1)) u_sup (
    .clk(clk), .reset(reset), .start(start),
    .char14(ch[0]), .char13(ch[1]), .char12(ch[2]), .char11(ch[3]), .char10(ch[4]),
    .char9(ch[5]), .char8(ch[6]), .char7(ch[7]), .char6(ch[8]), .char5(ch[9]),
    .char4(ch[10]), .char3(ch[11]), .char2(ch[12]), .char1(ch[13]),
    .tx(tx_w[0]), .busy(busy_w[0]), .done(done_w[0])
  );

  dec_ascii_uart_tx #(.CLKS_PER_BIT(CPB), .LEADING_ZERO_SUPPRESS(1'b0)) u_raw (
    .clk(clk), .reset(reset), .start(start),
    .char14(ch[0]), .char13(ch[1]), .char12(ch[2]), .char11(ch[3]), .char10(ch[4]),
    .char9(ch[5]), .char8(ch[6]), .char7(ch[7]), .char6(ch[8]), .char5(ch[9]),
    .char4(ch[10]), .char3(ch[11]), .char2(ch[12]), .char1(ch[13]),
    .tx(tx_w[1]), .busy(busy_w[1]), .done(done_w[1])
  );

  task automatic chk(input string name, input logic [63:0] act_v, input logic [63:0] exp_v);
    nvec++;
    if (act_v !== exp_v) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act_v, exp_v, cyc);
    end
  endtask

  function automatic int msz(input int d);
    return (d == 0) ? mq0.size() : mq1.size();
  endfunction

  function automatic int bsz(input int d);
    return (d == 0) ? bq0.size() : bq1.size();
  endfunction

  function automatic msg_t mpop(input int d);
    return (d == 0) ? mq0.pop_front() : mq1.pop_front();
  endfunction

  function automatic logic [7:0] bpop(input int d);
    return (d == 0) ? bq0.pop_front() : bq1.pop_front();
  endfunction

  function automatic logic [FRAME-1:0] frame_bits(input logic [7:0] b);
    logic [9:0]       fb;
    logic [FRAME-1:0] f;
    fb = {1'b1, b, 1'b0};
    for (int j = 0; j < 10; j++)
      for (int r = 0; r < int'(CPB); r++)
        f[j*CPB + r] = fb[j];
    return f;
  endfunction

  // Reference string: optional leading-'0' removal (char1 always kept), then CR LF.
  task automatic push_msg(input int d, input int s);
    int   fi;
    msg_t m;
    logic [7:0] bytes[$];
    fi = 0;
    if (d == 0) begin
      fi = 13;
      for (int i = 0; i < 13; i++) begin
        if (ch[i] != 6'd48) begin
          fi = i;
          break;
        end
      end
    end
    for (int i = fi; i < 14; i++) bytes.push_back({2'b00, ch[i]});
    bytes.push_back(8'h0D);
    bytes.push_back(8'h0A);
    m.n = bytes.size();
    m.s = s + 2;
    foreach (bytes[i]) begin
      if (d == 0) bq0.push_back(bytes[i]);
      else        bq1.push_back(bytes[i]);
    end
    if (d == 0) mq0.push_back(m);
    else        mq1.push_back(m);
    free_at[d] = s + m.n * FRAME + 3;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(posedge clk);
    #1;
  endtask

  // Holds start for len edges; each edge is accepted only if that instance is idle by then.
  task automatic pulse_start(input int len, output int s_first);
    int s;
    start   = 1'b1;
    s_first = cyc + 1;
    for (int j = 0; j < len; j++) begin
      s = cyc + 1;
      for (int d = 0; d < 2; d++)
        if (s >= free_at[d]) push_msg(d, s);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int lim;
    lim = (free_at[0] > free_at[1]) ? free_at[0] : free_at[1];
    wait_cyc(lim);
    @(negedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    bq0.delete(); bq1.delete(); mq0.delete(); mq1.delete();
    free_at[0] = 0;
    free_at[1] = 0;
    repeat (n) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset_tx[%0d]", d), 64'(tx_w[d]), 64'd1);
      chk($sformatf("reset_busy[%0d]", d), 64'(busy_w[d]), 64'd0);
      chk($sformatf("reset_done[%0d]", d), 64'(done_w[d]), 64'd0);
    end
    reset = 1'b0;
  endtask

  task automatic set_str(input string s);
    for (int i = 0; i < 14; i++) ch[i] = 6'(s.getc(i));
  endtask

  task automatic set_rand(input int nz);
    for (int i = 0; i < 14; i++) begin
      if (i < nz)                        ch[i] = 6'd48;
      else if ($urandom_range(0, 4) == 0) ch[i] = 6'($urandom);
      else                               ch[i] = 6'(48 + $urandom_range(0, 9));
    end
  endtask

  // UART monitor: captures whole 10-bit frames cycle by cycle and checks message timing.
  task automatic mon_step(input int d);
    msg_t       m;
    logic [7:0] b;
    if (reset) begin
      act[d]    = 1'b0;
      in_msg[d] = 1'b0;
      fin[d]    = 1'b0;
      return;
    end
    if (done_w[d]) begin
      chk($sformatf("done_expected[%0d]", d), 64'(fin[d]), 64'd1);
      if (fin[d]) begin
        chk($sformatf("done_latency[%0d]", d), 64'(cyc - t0[d]), 64'(nb[d] * FRAME));
        chk($sformatf("busy_at_done[%0d]", d), 64'(busy_w[d]), 64'd0);
      end
      fin[d] = 1'b0;
    end
    if (!act[d] && tx_w[d] == 1'b0) begin
      act[d] = 1'b1;
      cnt[d] = 0;
      if (!in_msg[d]) begin
        if (msz(d) == 0) begin
          chk($sformatf("msg_expected[%0d]", d), 64'(msz(d)), 64'd1);
        end else begin
          m = mpop(d);
          chk($sformatf("first_fall_cycle[%0d]", d), 64'(cyc), 64'(m.s));
          chk($sformatf("busy_at_first_fall[%0d]", d), 64'(busy_w[d]), 64'd1);
          in_msg[d] = 1'b1;
          t0[d]     = cyc;
          rem[d]    = m.n;
          nb[d]     = m.n;
        end
      end
    end
    if (act[d]) begin
      sh[d][cnt[d]] = tx_w[d];
      cnt[d]++;
      if (cnt[d] == int'(FRAME)) begin
        act[d] = 1'b0;
        if (bsz(d) == 0) begin
          chk($sformatf("byte_expected[%0d]", d), 64'(bsz(d)), 64'd1);
        end else begin
          b = bpop(d);
          chk($sformatf("frame[%0d] byte %02h", d, b), 64'(sh[d]), 64'(frame_bits(b)));
        end
        chk($sformatf("busy_in_frame[%0d]", d), 64'(busy_w[d]), 64'd1);
        if (in_msg[d]) begin
          rem[d]--;
          if (rem[d] == 0) begin
            in_msg[d] = 1'b0;
            fin[d]    = 1'b1;
          end
        end
      end
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) mon_step(d);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, s1;
    for (int i = 0; i < 14; i++) ch[i] = 6'd48;
    free_at[0] = 0;
    free_at[1] = 0;
    do_reset(3);

    set_str("00000000012345"); pulse_start(1, s0); wait_idle();
    set_str("00000000000000"); pulse_start(1, s0); wait_idle();
    set_str("00000000000007"); pulse_start(1, s0); wait_idle();

    // Start during the DONE cycle is dropped; the next cycle is accepted.
    set_str("00000000000000"); pulse_start(1, s0);
    wait_cyc(s0 + 3 * FRAME + 1);
    set_str("00000000000042"); pulse_start(2, s1);
    wait_idle();

    // Second start and new digits while busy must not disturb the latched string.
    set_str("00000000004096"); pulse_start(1, s0);
    repeat (60) @(posedge clk);
    #1;
    set_str("99999999999999"); pulse_start(1, s1);
    set_str("12121212121212");
    wait_idle();

    // Reset in the data bits of the second byte, then a clean message.
    set_str("00000000000123"); pulse_start(1, s0);
    wait_cyc(s0 + 2 + FRAME + CPB + 6);
    do_reset(1);
    repeat (3) @(posedge clk);
    #1;
    set_str("00000000000456"); pulse_start(1, s0); wait_idle();

    repeat (20) begin
      set_rand($urandom_range(0, 14));
      pulse_start(1, s0);
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 200)) @(posedge clk);
        #1;
        set_rand($urandom_range(0, 14));
        pulse_start($urandom_range(1, 2), s1);
      end
      wait_idle();
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    for (int d = 0; d < 2; d++) begin
      chk($sformatf("leftover_bytes[%0d]", d), 64'(bsz(d)), 64'd0);
      chk($sformatf("leftover_msgs[%0d]", d), 64'(msz(d)), 64'd0);
      chk($sformatf("missing_done[%0d]", d), 64'(fin[d]), 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/dec_ascii_uart_tx.md
# dec_ascii_uart_tx

Downstream consumer of the 64-bit binary-to-decimal converter. On a `start` pulse it snapshots the converter's 14 ASCII digit characters (6-bit codes, `char14` most significant) and optionally strips leading zeros. It then appends CR LF and serialises the resulting string as 8N1 UART frames on `tx`, so HIL telemetry values can be read on a PC terminal.

## Interface

- `CLKS_PER_BIT`, 868: clock cycles per UART bit (100 MHz / 115200); legal range ≥2.
- `LEADING_ZERO_SUPPRESS`, 1: when 1, leading `'0'` (48) characters are not sent; when 0, all 14 digits are sent.

- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request to send the current digit string; sampled only when `busy`=0.
- `char14` … `char1`  in  6 each  ASCII digit codes from the converter (`char14` = MSD, `char1` = LSD).
- `tx`  out  1  UART serial output, idle high.
- `busy`  out  1  high from the edge that accepts `start` through the end of the last stop bit.
- `done`  out  1  one-cycle pulse when the string (including CR LF) has been fully sent.

## Operation

- Reset values: `tx`=1, `busy`=0, `done`=0, state IDLE, all counters 0.
- States:
  - **IDLE**: `tx`=1. `start`=1 → latch `char14..char1` into 14 internal 6-bit registers, set `busy`, go to SCAN.
  - **SCAN**, 1 cycle: compute the first index to send.
    - `LEADING_ZERO_SUPPRESS`=1: first index is the most significant char ≠ 48. If all 14 chars equal 48, send only `char1`.
    - `LEADING_ZERO_SUPPRESS`=0: first index is `char14`.
    - Go to START.
  - **START**: `tx`=0 for `CLKS_PER_BIT` cycles → DATA.
  - **DATA**: 8 bits of the current byte, LSB first, each `CLKS_PER_BIT` cycles → STOP.
  - **STOP**: `tx`=1 for `CLKS_PER_BIT` cycles. If more bytes remain → START, with no idle gap between frames. Otherwise → DONE.
  - **DONE**, 1 cycle: `done`=1, `busy`=0, `tx`=1 → IDLE.
- Byte formation:
  - Digit byte = {2'b00, char}; chars are sent unchanged, with no validity check on the 48–57 range.
  - Digits are followed by 0x0D, then 0x0A.
- Character index: 4-bit, covering 14 digit slots plus CR and LF. Bit counter: 3-bit. Baud counter: width `$clog2(CLKS_PER_BIT)`; counts 0..CLKS_PER_BIT-1, then wraps.
- The input chars may change freely after latch; only the latched copy is transmitted.
- `start` while `busy`=1 is ignored and not queued. `start` during the DONE cycle is ignored.
- `reset` asserted in any state:
  - Next edge: `tx`=1, `busy`=0, `done`=0, IDLE.
  - The partial frame is abandoned and no `done` is issued.
  - `reset` dominates a simultaneous `start`.

## Timing

- Edge k samples `start`=1: `busy`=1 after k, SCAN during k+1, `tx`=0 after edge k+2.
- N digits sent: the message occupies (N+2)·10·`CLKS_PER_BIT` cycles on `tx`.
- `done` is high the cycle after the final stop bit completes; `busy` deasserts on the same edge that `done` asserts.
- Earliest next accepted `start`: the cycle after `done`, i.e. `busy`=0 and state IDLE.
- Throughput: one new string per (N+2)·10·`CLKS_PER_BIT`+3 cycles.

## Test plan

All scenarios use `CLKS_PER_BIT`=4.

- **Suppressed string:** chars encode 00000000012345, suppression on, pulse `start` → bytes 0x31, 0x32, 0x33, 0x34, 0x35, 0x0D, 0x0A; 280 `tx` cycles; single `done` pulse; `busy` high throughout.
- **All zeros:** all chars 48, suppression on → bytes 0x30, 0x0D, 0x0A; 120 cycles; `done` once.
- **No suppression:** `LEADING_ZERO_SUPPRESS`=0, chars 00000000000007 → 13×0x30, 0x37, 0x0D, 0x0A; 16 frames, 640 cycles.
- **Bit-level frame:** byte 0x31 → `tx` sequence 0, 1, 0, 0, 0, 1, 1, 0, 0, 1; each level held exactly 4 cycles; first falling edge exactly 2 cycles after `start` is sampled.
- **Start while busy / changing inputs:** pulse `start` again mid-transmission and change the chars → original string sent unchanged; exactly one `done`.
- **Reset mid-operation:** assert `reset` during DATA of the second byte → `tx`=1, `busy`=0 next edge, no `done`; a following `start` sends a complete correct string.
